uart_frame_ctrl: RTL and testbench

//  Frame-level controller between the uart_rx byte stream (po_data/po_flag) and the DDR write FIFO.

---
 rtl/uart_frame_ctrl.sv | 129 ++++++++++++
 tb/tb_uart_frame_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: frames a UART byte stream into FIFO words with header, length, checksum and timeout
module uart_frame_ctrl #(
  parameter int          UART_BPS      = 9600,
  parameter int          CLK_FREQ      = 50_000_000,
  parameter int          FIFO_WR_WIDTH = 16,
  parameter int          FIFO_WR_BYTE  = 2,
  parameter logic [7:0]  HDR0          = 8'h55,
  parameter logic [7:0]  HDR1          = 8'hAA,
  parameter int          TIMEOUT_BYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               byte_data,
  input  logic                     byte_valid,
  input  logic                     fifo_full,
  output logic [FIFO_WR_WIDTH-1:0] fifo_wr_data,
  output logic                     fifo_wr_en,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic [1:0]               err_code,
  output logic                     busy
);
  localparam int          BW    = FIFO_WR_BYTE > 1 ? $clog2(FIFO_WR_BYTE) : 1;
  localparam logic [31:0] TC_M1 = 32'(CLK_FREQ / UART_BPS * 10 * TIMEOUT_BYTES - 1);

  typedef enum logic [2:0] {IDLE, HDR, LEN_H, LEN_L, PAYLOAD, CHK} state_t;

  state_t                   r_state, w_next;
  logic [7:0]               r_len_h, r_sum;
  logic [15:0]              r_rem;
  logic [FIFO_WR_WIDTH-1:0] r_acc, w_word;
  logic [BW-1:0]            r_bidx;
  logic                     r_ovf;
  logic [31:0]              r_tcnt;
  logic                     w_last, w_cmpl, w_tout, w_wr, w_ovf_set, w_done, w_err;
  logic [1:0]               w_code;

  assign busy = r_state != IDLE;

  // next state, word assembly and the decisions that become registered strobes
  always_comb begin
    w_next    = r_state;
    w_wr      = 1'b0;
    w_ovf_set = 1'b0;
    w_done    = 1'b0;
    w_err     = 1'b0;
    w_code    = 2'd0;
    w_last    = r_rem == 16'd1;
    w_cmpl    = w_last || r_bidx == BW'(FIFO_WR_BYTE - 1);
    w_tout    = r_state != IDLE && !byte_valid && r_tcnt == TC_M1;
    w_word    = r_acc;
    for (int k = 0; k < FIFO_WR_BYTE; k++)
      if (r_bidx == BW'(k)) w_word[FIFO_WR_WIDTH-1-8*k -: 8] = byte_data;
    if (w_tout) begin
      w_next = IDLE;
      w_err  = 1'b1;
      w_code = 2'd1;
    end else if (byte_valid) begin
      case (r_state)
        IDLE:    w_next = byte_data == HDR0 ? HDR : IDLE;
        HDR:     w_next = byte_data == HDR1 ? LEN_H : byte_data == HDR0 ? HDR : IDLE;
        LEN_H:   w_next = LEN_L;
        LEN_L: begin
          w_err  = {r_len_h, byte_data} == 16'd0;
          w_code = w_err ? 2'd3 : 2'd0;
          w_next = w_err ? IDLE : PAYLOAD;
        end
        PAYLOAD: begin
          w_wr      = w_cmpl && !fifo_full;
          w_ovf_set = w_cmpl && fifo_full;
          w_next    = w_last ? CHK : PAYLOAD;
        end
        CHK: begin
          w_done = !r_ovf && byte_data == r_sum;
          w_err  = !w_done;
          w_code = r_ovf ? 2'd3 : 2'd2;
          w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // frame datapath, idle timer and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len_h      <= '0;
      r_sum        <= '0;
      r_rem        <= '0;
      r_acc        <= '0;
      r_bidx       <= '0;
      r_ovf        <= 1'b0;
      r_tcnt       <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      r_tcnt       <= (r_state == IDLE || byte_valid || w_tout) ? 32'd0 : r_tcnt + 32'd1;
      fifo_wr_en   <= w_wr;
      fifo_wr_data <= w_wr ? w_word : fifo_wr_data;
      frame_done   <= w_done;
      frame_err    <= w_err;
      err_code     <= w_err ? w_code : err_code;
      if (byte_valid && r_state == LEN_H) r_len_h <= byte_data;
      if (byte_valid && r_state == LEN_L) begin
        r_rem  <= {r_len_h, byte_data};
        r_acc  <= '0;
        r_bidx <= '0;
        r_sum  <= '0;
        r_ovf  <= 1'b0;
      end
      if (byte_valid && r_state == PAYLOAD) begin
        r_rem  <= r_rem - 16'd1;
        r_sum  <= r_sum + byte_data;
        r_acc  <= w_cmpl ? '0 : w_word;
        r_bidx <= w_cmpl ? '0 : r_bidx + BW'(1);
        r_ovf  <= r_ovf | w_ovf_set;
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed and randomized frames checked against a frame-level reference model
module tb_uart_frame_ctrl;
  localparam int CF = 1000, BPS = 100, TOB = 4;
  localparam int TC = CF / BPS * 10 * TOB;

  logic        clk = 1'b0, rst_n = 1'b0, byte_valid = 1'b0, fifo_full = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic [15:0] fifo_wr_data;
  logic        fifo_wr_en, frame_done, frame_err, busy;
  logic [1:0]  err_code;

  int errors = 0, checks = 0;
  logic [15:0] obs_w[$], exp_w[$];
  logic [2:0]  obs_e[$], exp_e[$];
  logic [7:0]  pq[$];

  uart_frame_ctrl #(.UART_BPS(BPS), .CLK_FREQ(CF), .FIFO_WR_WIDTH(16), .FIFO_WR_BYTE(2),
                    .HDR0(8'h55), .HDR1(8'hAA), .TIMEOUT_BYTES(TOB)) dut (
    .clk(clk), .rst_n(rst_n), .byte_data(byte_data), .byte_valid(byte_valid),
    .fifo_full(fifo_full), .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en),
    .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code), .busy(busy));

  always #5 clk = ~clk;

  // capture every write and status pulse; events: 0 = done, {1,code} = error
  always @(negedge clk) begin
    if (fifo_wr_en) obs_w.push_back(fifo_wr_data);
    if (frame_done) obs_e.push_back(3'd0);
    if (frame_err)  obs_e.push_back({1'b1, err_code});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      fifo_full = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    fifo_full = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic full);
    byte_data = b; byte_valid = 1'b1; fifo_full = full;
    @(posedge clk); #1;
    byte_valid = 1'b0; fifo_full = 1'b0;
  endtask

  task automatic compare(input string tag);
    idle(4);
    chk({tag, "_nwords"}, obs_w.size(), exp_w.size());
    while (obs_w.size() > 0 && exp_w.size() > 0) chk({tag, "_word"}, obs_w.pop_front(), exp_w.pop_front());
    chk({tag, "_nevents"}, obs_e.size(), exp_e.size());
    while (obs_e.size() > 0 && exp_e.size() > 0) chk({tag, "_event"}, obs_e.pop_front(), exp_e.pop_front());
    chk({tag, "_busy"}, busy, 1'b0);
    obs_w.delete(); exp_w.delete(); obs_e.delete(); exp_e.delete();
  endtask

  // send the frame carrying pq; cb<0 means correct checksum; full_w = index of the word hit by fifo_full
  task automatic run_frame(input int cb, input int full_w, input int gmax, input int strays);
    int n, nw;
    logic [7:0] sum, b;
    logic [15:0] ln;
    n = pq.size(); nw = (n + 1) / 2; ln = 16'(n); sum = 8'h00;
    foreach (pq[i]) sum += pq[i];
    repeat (strays) begin
      b = 8'($urandom_range(0, 255));
      send(b == 8'h55 ? 8'h54 : b, 1'($urandom_range(0, 1)));
    end
    send(8'h55, 1'($urandom_range(0, 1))); idle($urandom_range(0, gmax));
    send(8'hAA, 1'($urandom_range(0, 1))); idle($urandom_range(0, gmax));
    send(ln[15:8], 1'($urandom_range(0, 1))); idle($urandom_range(0, gmax));
    send(ln[7:0], 1'($urandom_range(0, 1))); idle($urandom_range(0, gmax));
    for (int i = 0; i < n; i++) begin
      send(pq[i], (i % 2 == 1 || i == n - 1) ? (i / 2 == full_w) : 1'($urandom_range(0, 1)));
      idle($urandom_range(0, gmax));
    end
    send(cb < 0 ? sum : 8'(cb), 1'($urandom_range(0, 1)));
    for (int w = 0; w < nw; w++)
      if (w != full_w) exp_w.push_back({pq[2*w], (2*w + 1 < n) ? pq[2*w+1] : 8'h00});
    exp_e.push_back((full_w >= 0 && full_w < nw) ? 3'b111 :
                    (cb >= 0 && 8'(cb) != sum) ? 3'b110 : 3'b000);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", fifo_wr_en, 0); chk("rst_wr_data", fifo_wr_data, 0);
    chk("rst_done", frame_done, 0);  chk("rst_err", frame_err, 0);
    chk("rst_code", err_code, 0);    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(2);
    // basic frame with exact write/done latency
    send(8'h55, 0); chk("t1_busy", busy, 1);
    send(8'hAA, 0); send(8'h00, 0); send(8'h04, 0); send(8'h11, 0);
    send(8'h22, 0);
    chk("t1_wr_en", fifo_wr_en, 1); chk("t1_wr_data", fifo_wr_data, 16'h1122);
    idle(1);
    chk("t1_wr_en_low", fifo_wr_en, 0); chk("t1_wr_hold", fifo_wr_data, 16'h1122);
    send(8'h33, 0); send(8'h44, 0); send(8'hAA, 0);
    chk("t1_done", frame_done, 1); chk("t1_err", frame_err, 0); chk("t1_busy_end", busy, 0);
    exp_w.push_back(16'h1122); exp_w.push_back(16'h3344); exp_e.push_back(3'b000);
    compare("t1");
    // padded short final word
    pq = '{8'h01, 8'h02, 8'h03}; run_frame(-1, -1, 0, 0); compare("t2");
    // bad checksum
    pq = '{8'h10, 8'h20}; run_frame(0, -1, 0, 0); compare("t3");
    chk("t3_code_hold", err_code, 2);
    // timeout discards the partial word
    send(8'h55, 0); send(8'hAA, 0); send(8'h00, 0); send(8'h04, 0); send(8'h11, 0); send(8'h22, 0);
    exp_w.push_back(16'h1122);
    send(8'h33, 0);
    idle(TC + 5);
    exp_e.push_back(3'b101);
    compare("t4");
    chk("t4_code_hold", err_code, 1);
    pq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF}; run_frame(-1, -1, 1, 0); compare("t4_next");
    // idle gap just under the limit is harmless
    send(8'h55, 0); send(8'hAA, 0); send(8'h00, 0); send(8'h01, 0);
    idle(TC - 3);
    send(8'h5A, 0); send(8'h5A, 0);
    exp_w.push_back(16'h5A00); exp_e.push_back(3'b000);
    compare("gap");
    // stray bytes and header resync
    send(8'h12, 0); send(8'hAA, 0); send(8'h55, 0); send(8'h55, 0); send(8'hAA, 0);
    send(8'h00, 0); send(8'h01, 0); send(8'h7F, 0); send(8'h7F, 0);
    exp_w.push_back(16'h7F00); exp_e.push_back(3'b000);
    compare("t5");
    // zero length
    send(8'h55, 0); send(8'hAA, 0); send(8'h00, 0); send(8'h00, 0);
    chk("zlen_err", frame_err, 1); chk("zlen_code", err_code, 3);
    exp_e.push_back(3'b111);
    compare("zlen");
    // overflow on second word
    pq = '{8'h11, 8'h22, 8'h33, 8'h44}; run_frame(-1, 1, 0, 0); compare("t6");
    // reset mid-payload
    send(8'h55, 0); send(8'hAA, 0); send(8'h00, 0); send(8'h04, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    exp_w.push_back(16'h1122);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6r_wr_en", fifo_wr_en, 0); chk("t6r_wr_data", fifo_wr_data, 0);
    chk("t6r_done", frame_done, 0);  chk("t6r_err", frame_err, 0);
    chk("t6r_code", err_code, 0);    chk("t6r_busy", busy, 0);
    rst_n = 1'b1;
    send(8'h44, 0); send(8'hAA, 0);
    compare("t6r");
    // back-to-back frames
    pq = '{8'hA1}; run_frame(-1, -1, 0, 0);
    pq = '{8'hB1, 8'hB2}; run_frame(-1, -1, 0, 0);
    compare("b2b");
    // randomized frames
    for (int f = 0; f < 40; f++) begin
      int n, cb, fw;
      n = $urandom_range(1, 9);
      pq.delete();
      repeat (n) pq.push_back(8'($urandom_range(0, 255)));
      cb = -1;
      if ($urandom_range(0, 3) == 0) begin
        logic [7:0] s;
        s = 8'h00;
        foreach (pq[i]) s += pq[i];
        cb = int'(8'(s + 8'($urandom_range(1, 255))));
      end
      fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (n + 1) / 2 - 1) : -1;
      run_frame(cb, fw, 3, $urandom_range(0, 2));
      compare("rnd");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
